// File: rtl/per_bus_master.sv
// Peripheral bus initiator: turns single request/response transactions into
// registered per_* bus cycles, including atomic bit-set/bit-clear.
module per_bus_master #(
    parameter logic RMW_EN = 1'b1
) (
    input  logic        mclk,
    input  logic        puc,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_byte,
    input  logic [8:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_wen,
    input  logic [15:0] per_dout
);

    typedef enum logic [2:0] {
        IDLE,
        BUS_RD,
        BUS_WR,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        clr_q, clr_d;
    logic        byte_q, byte_d;
    logic [8:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        per_en_q, per_en_d;
    logic [1:0]  per_wen_q, per_wen_d;
    logic [7:0]  per_addr_q, per_addr_d;
    logic [15:0] per_din_q, per_din_d;

    logic [7:0]  rd_lane;
    logic [15:0] rd_val;
    logic [15:0] mask;
    logic [15:0] mod_val;
    logic        req_bad;

    function automatic logic [1:0] lane_wen(input logic is_byte, input logic odd);
        if (!is_byte) begin
            return 2'b11;
        end
        return odd ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        rd_lane = addr_q[0] ? per_dout[15:8] : per_dout[7:0];
        rd_val  = byte_q ? {8'h00, rd_lane} : per_dout;
        mask    = byte_q ? {8'h00, wdata_q[7:0]} : wdata_q;
        mod_val = clr_q ? (rd_val & ~mask) : (rd_val | mask);
        req_bad = (!req_byte && req_addr[0]) || (req_op[1] && !RMW_EN);

        state_d    = state_q;
        clr_d      = clr_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        per_en_d   = 1'b0;
        per_wen_d  = 2'b00;
        per_addr_d = '0;
        per_din_d  = '0;

        // Bus outputs are registered, so each state computes the values the
        // bus must show during the state it is about to enter.
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    clr_d   = req_op[0];
                    byte_d  = req_byte;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else begin
                        per_en_d   = 1'b1;
                        per_addr_d = req_addr[8:1];
                        case (req_op)
                            2'b00: state_d = BUS_RD;
                            2'b01: begin
                                state_d   = BUS_WR;
                                per_wen_d = lane_wen(req_byte, req_addr[0]);
                                per_din_d = req_byte ? {req_wdata[7:0], req_wdata[7:0]}
                                                     : req_wdata;
                            end
                            default: state_d = RMW_RD;
                        endcase
                    end
                end
            end
            BUS_RD: begin
                rdata_d = rd_val;
                state_d = RESP;
            end
            RMW_RD: begin
                // Old value is captured and modified in the same edge so the
                // write cycle follows the read with no gap on per_en.
                rdata_d    = rd_val;
                state_d    = RMW_WR;
                per_en_d   = 1'b1;
                per_addr_d = addr_q[8:1];
                per_wen_d  = lane_wen(byte_q, addr_q[0]);
                per_din_d  = byte_q ? {mod_val[7:0], mod_val[7:0]} : mod_val;
            end
            BUS_WR, RMW_WR: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc) begin
            state_q    <= IDLE;
            clr_q      <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            per_en_q   <= 1'b0;
            per_wen_q  <= 2'b00;
            per_addr_q <= '0;
            per_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            per_en_q   <= per_en_d;
            per_wen_q  <= per_wen_d;
            per_addr_q <= per_addr_d;
            per_din_q  <= per_din_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign per_en    = per_en_q;
    assign per_wen   = per_wen_q;
    assign per_addr  = per_addr_q;
    assign per_din   = per_din_q;

endmodule

// File: tb/tb_per_bus_master.sv
// Bench for per_bus_master: vector table, corner-case sequences and random
// transactions checked against a word-array peripheral reference model.
module tb_per_bus_master;

    logic        mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        puc;
    logic        req_valid, req_valid0;
    logic        req_ready, req_ready0;
    logic [1:0]  req_op;
    logic        req_byte;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_valid0;
    logic        rsp_ready;
    logic [15:0] rsp_rdata, rsp_rdata0;
    logic        rsp_err, rsp_err0;
    logic [7:0]  per_addr, per_addr0;
    logic [15:0] per_din, per_din0;
    logic        per_en, per_en0;
    logic [1:0]  per_wen, per_wen0;
    logic [15:0] per_dout, per_dout0;

    per_bus_master #(.RMW_EN(1'b1)) u_dut (
        .mclk(mclk), .puc(puc),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_wen(per_wen), .per_dout(per_dout)
    );

    per_bus_master #(.RMW_EN(1'b0)) u_dut0 (
        .mclk(mclk), .puc(puc),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .per_addr(per_addr0), .per_din(per_din0),
        .per_en(per_en0), .per_wen(per_wen0), .per_dout(per_dout0)
    );

    // Peripheral: 256-word register file with byte enables, combinational read.
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        mem_clr, pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge mclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (per_en) begin
            if (per_wen[0]) mem[per_addr][7:0]  <= per_din[7:0];
            if (per_wen[1]) mem[per_addr][15:8] <= per_din[15:8];
        end
    end

    assign per_dout  = per_en  ? mem[per_addr] : 16'h0000;
    assign per_dout0 = per_en0 ? 16'hBEEF      : 16'h0000;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic preload(input logic [7:0] w, input logic [15:0] v);
        pre_addr = w;
        pre_data = v;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
        ref_mem[w] = v;
    endtask

    task automatic clear_mem();
        mem_clr = 1'b1;
        step();
        mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    // Observations of the last transaction.
    logic [15:0] t_rdata, t_din_last;
    logic        t_err, t_idle_ok;
    int          t_lat, t_nbus, t_bus_lat;
    logic [1:0]  t_wen_first, t_wen_last;
    logic [7:0]  t_addr_first, t_addr_last;

    task automatic txn(input logic [1:0] op, input logic bt, input logic [8:0] addr,
                       input logic [15:0] wd, input int hold, input logic [15:0] e_rdata);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            step();
            guard++;
        end
        chk("req_ready_before", req_ready, 1);
        req_op = op; req_byte = bt; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        t_lat = 1; t_nbus = 0; t_bus_lat = 0; t_idle_ok = 1'b1;
        t_wen_first = 2'b00; t_wen_last = 2'b00; t_din_last = '0;
        t_addr_first = '0; t_addr_last = '0;
        forever begin
            if (per_en) begin
                if (t_nbus == 0) begin
                    t_addr_first = per_addr;
                    t_wen_first  = per_wen;
                    t_bus_lat    = t_lat;
                end
                t_nbus++;
                t_addr_last = per_addr;
                t_wen_last  = per_wen;
                t_din_last  = per_din;
            end else if (per_wen != 2'b00 || per_din != 16'h0000) begin
                t_idle_ok = 1'b0;
            end
            if (rsp_valid || t_lat >= 10) break;
            step();
            t_lat++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
        t_rdata = rsp_rdata;
        t_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, e_rdata);
            chk("hold_req_ready", req_ready, 0);
            if (per_en || per_wen != 2'b00 || per_din != 16'h0000) t_idle_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("req_ready_after", req_ready, 1);
    endtask

    // Reference model: expected response and effect on the peripheral words.
    task automatic ref_exec(input logic [1:0] op, input logic bt, input logic [8:0] addr,
                            input logic [15:0] wd, output logic [15:0] e_rdata,
                            output logic e_err, output int e_lat, output int e_nbus,
                            output logic [1:0] e_wen, output logic [15:0] e_din);
        logic [7:0]  w;
        logic [15:0] old, sel, m, v;
        logic [7:0]  b;
        w = addr[8:1];
        old = ref_mem[w];
        sel = bt ? (addr[0] ? {8'h00, old[15:8]} : {8'h00, old[7:0]}) : old;
        m   = bt ? {8'h00, wd[7:0]} : wd;
        e_rdata = '0; e_err = 1'b0; e_wen = 2'b00; e_din = '0;
        if (!bt && addr[0]) begin
            e_err = 1'b1; e_lat = 1; e_nbus = 0;
            return;
        end
        if (op == 2'd0) begin
            e_rdata = sel; e_lat = 2; e_nbus = 1;
            return;
        end
        if (op == 2'd1) begin
            v = wd; e_lat = 2; e_nbus = 1;
        end else begin
            v = (op == 2'd2) ? (sel | m) : (sel & ~m);
            e_rdata = sel; e_lat = 3; e_nbus = 2;
        end
        b = v[7:0];
        if (!bt) begin
            ref_mem[w] = v; e_wen = 2'b11; e_din = v;
        end else begin
            if (addr[0]) ref_mem[w][15:8] = b;
            else         ref_mem[w][7:0]  = b;
            e_wen = addr[0] ? 2'b10 : 2'b01;
            e_din = {b, b};
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        bt;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] pre;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          nbus;
        logic [1:0]  wen;
        logic [15:0] din;
        logic [7:0]  paddr;
        logic [15:0] mem_after;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e_rdata, e_din;
        logic        e_err;
        int          e_lat, e_nbus, cnt;
        logic [1:0]  e_wen, op;
        logic        bt;
        logic [8:0]  addr;
        logic [15:0] wd;

        //          op    bt    addr    wd        pre       rdata     err  lat nbus wen    din       paddr  mem_after
        vecs[0] = '{2'd0, 1'b0, 9'h056, 16'h0000, 16'h3000, 16'h3000, 1'b0, 2, 1, 2'b00, 16'h0000, 8'h2B, 16'h3000};
        vecs[1] = '{2'd1, 1'b1, 9'h058, 16'h000E, 16'h1234, 16'h0000, 1'b0, 2, 1, 2'b01, 16'h0E0E, 8'h2C, 16'h120E};
        vecs[2] = '{2'd0, 1'b1, 9'h057, 16'h0000, 16'h3000, 16'h0030, 1'b0, 2, 1, 2'b00, 16'h0000, 8'h2B, 16'h3000};
        vecs[3] = '{2'd2, 1'b0, 9'h120, 16'h0004, 16'h0081, 16'h0081, 1'b0, 3, 2, 2'b11, 16'h0085, 8'h90, 16'h0085};
        vecs[4] = '{2'd0, 1'b0, 9'h057, 16'h0000, 16'h3000, 16'h0000, 1'b1, 1, 0, 2'b00, 16'h0000, 8'h00, 16'h3000};
        vecs[5] = '{2'd3, 1'b1, 9'h121, 16'h0001, 16'h0385, 16'h0003, 1'b0, 3, 2, 2'b10, 16'h0202, 8'h90, 16'h0285};
        vecs[6] = '{2'd1, 1'b1, 9'h0FF, 16'hABCD, 16'h1111, 16'h0000, 1'b0, 2, 1, 2'b10, 16'hCDCD, 8'h7F, 16'hCD11};
        vecs[7] = '{2'd1, 1'b0, 9'h1FE, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 2, 1, 2'b11, 16'hBEEF, 8'hFF, 16'hBEEF};
        vecs[8] = '{2'd2, 1'b1, 9'h040, 16'hFF80, 16'h5501, 16'h0001, 1'b0, 3, 2, 2'b01, 16'h8181, 8'h20, 16'h5581};
        vecs[9] = '{2'd3, 1'b0, 9'h0A0, 16'h00F0, 16'hFFFF, 16'hFFFF, 1'b0, 3, 2, 2'b11, 16'hFF0F, 8'h50, 16'hFF0F};

        puc = 1'b1; mem_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (3) step();

        chk("rst_per_en", per_en, 0);
        chk("rst_per_wen", per_wen, 0);
        chk("rst_per_addr", per_addr, 0);
        chk("rst_per_din", per_din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_valid0", rsp_valid0, 0);
        puc = 1'b0; mem_clr = 1'b0;
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_req_ready0", req_ready0, 1);

        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].addr[8:1], vecs[i].pre);
            txn(vecs[i].op, vecs[i].bt, vecs[i].addr, vecs[i].wd, 0, vecs[i].rdata);
            chk($sformatf("vec%0d_rdata", i), t_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), t_err, vecs[i].err);
            chk($sformatf("vec%0d_lat", i), t_lat, vecs[i].lat);
            chk($sformatf("vec%0d_nbus", i), t_nbus, vecs[i].nbus);
            chk($sformatf("vec%0d_idle_zero", i), t_idle_ok, 1);
            chk($sformatf("vec%0d_mem", i), mem[vecs[i].addr[8:1]], vecs[i].mem_after);
            if (vecs[i].nbus > 0) begin
                chk($sformatf("vec%0d_bus_lat", i), t_bus_lat, 1);
                chk($sformatf("vec%0d_wen", i), t_wen_last, vecs[i].wen);
                chk($sformatf("vec%0d_paddr_first", i), t_addr_first, vecs[i].paddr);
                chk($sformatf("vec%0d_paddr_last", i), t_addr_last, vecs[i].paddr);
                if (vecs[i].op != 2'd0) chk($sformatf("vec%0d_din", i), t_din_last, vecs[i].din);
                if (vecs[i].nbus == 2) chk($sformatf("vec%0d_rmw_rd_wen", i), t_wen_first, 2'b00);
            end
        end

        // Response held for 5 cycles with rsp_ready low.
        preload(8'h33, 16'hA5C3);
        txn(2'd0, 1'b0, 9'h066, 16'h0000, 5, 16'hA5C3);
        chk("hold_rdata", t_rdata, 16'hA5C3);
        chk("hold_idle_zero", t_idle_ok, 1);

        // Reset during RMW_RD: no write may reach the peripheral.
        preload(8'h10, 16'h00F0);
        req_op = 2'd2; req_byte = 1'b0; req_addr = 9'h020; req_wdata = 16'h000F;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("abort_rmw_rd_en", per_en, 1);
        chk("abort_rmw_rd_wen", per_wen, 2'b00);
        puc = 1'b1;
        step();
        puc = 1'b0;
        chk("abort_per_en", per_en, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (per_en || rsp_valid) cnt++;
            step();
        end
        chk("abort_quiet", cnt, 0);
        chk("abort_mem", mem[8'h10], 16'h00F0);

        // RMW disabled: bit-clear errors out with no bus cycle; reads still work.
        req_op = 2'd3; req_byte = 1'b0; req_addr = 9'h120; req_wdata = 16'h0004;
        req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        chk("norm_rsp_valid", rsp_valid0, 1);
        chk("norm_rsp_err", rsp_err0, 1);
        chk("norm_rsp_rdata", rsp_rdata0, 0);
        chk("norm_per_en", per_en0, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("norm_req_ready", req_ready0, 1);
        req_op = 2'd0; req_addr = 9'h002;
        req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        chk("norm_rd_en", per_en0, 1);
        step();
        chk("norm_rd_valid", rsp_valid0, 1);
        chk("norm_rd_rdata", rsp_rdata0, 16'hBEEF);
        chk("norm_rd_err", rsp_err0, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Random transactions against the reference model.
        clear_mem();
        for (int n = 0; n < 250; n++) begin
            op   = 2'($urandom_range(0, 3));
            bt   = 1'($urandom_range(0, 1));
            addr = 9'($urandom_range(0, 511));
            wd   = 16'($urandom);
            ref_exec(op, bt, addr, wd, e_rdata, e_err, e_lat, e_nbus, e_wen, e_din);
            txn(op, bt, addr, wd, $urandom_range(0, 3), e_rdata);
            chk("rnd_rdata", t_rdata, e_rdata);
            chk("rnd_err", t_err, e_err);
            chk("rnd_lat", t_lat, e_lat);
            chk("rnd_nbus", t_nbus, e_nbus);
            chk("rnd_idle_zero", t_idle_ok, 1);
            chk("rnd_mem", mem[addr[8:1]], ref_mem[addr[8:1]]);
            if (e_nbus > 0) begin
                chk("rnd_paddr_first", t_addr_first, addr[8:1]);
                chk("rnd_paddr_last", t_addr_last, addr[8:1]);
                chk("rnd_wen", t_wen_last, e_wen);
                if (op != 2'd0) chk("rnd_din", t_din_last, e_din);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/per_bus_master.md
Name: per_bus_master

Overview:
- Initiator for the peripheral bus: turns single request/response transactions into per_addr/per_din/per_en/per_wen cycles and captures per_dout.
- Supports word/byte read, word/byte write, and atomic bit-set/bit-clear (read-modify-write).
- Sits between a command source (debug bridge, DMA-lite sequencer) and the peripheral bus shared by the clock module, timers and GPIO.
- All bus outputs are registered; peripherals return per_dout combinationally in the same cycle as per_en.

Parameters:
RMW_EN, 1, 1 = ops 2'b10/2'b11 are supported; 0 = those ops return an error with no bus cycle

Ports:
mclk  input  1  main system clock, the only clock
puc  input  1  reset; synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; a transfer happens when req_valid & req_ready
req_op  input  2  00 read, 01 write, 10 bit-set, 11 bit-clear
req_byte  input  1  1 = byte access, 0 = word access
req_addr  input  9  byte address
req_wdata  input  16  write data, or bit mask for set/clear; byte ops use [7:0]
rsp_valid  output  1  response held until rsp_ready
rsp_ready  input  1  response consumer ready
rsp_rdata  output  16  read data; previous value for RMW; 0 for write
rsp_err  output  1  misaligned access or disabled op
per_addr  output  8  word address = req_addr[8:1]
per_din  output  16  bus write data
per_en  output  1  bus cycle strobe
per_wen  output  2  byte write enables
per_dout  input  16  OR-ed peripheral read data

Behaviour:
- Reset (puc=1 at a mclk edge):
  - state goes to IDLE.
  - per_en=0, per_wen=00, per_addr=0, per_din=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 from the first cycle after reset.
  - Reset mid-transaction aborts it; no response is produced and any partial RMW write is not issued.
- States: IDLE, BUS_RD, BUS_WR, RMW_RD, RMW_WR, RESP.
- IDLE, on accept, latches op, byte, addr and wdata, then:
  - Error if word access with addr[0]=1, or op is 10/11 with RMW_EN=0 → RESP with rsp_err=1, rdata=0, no bus cycle.
  - read → BUS_RD; write → BUS_WR; set/clear → RMW_RD.
- BUS_RD / RMW_RD:
  - per_en=1, per_wen=00.
  - per_dout is captured at the end of this cycle.
  - Word access: keep all 16 bits.
  - Byte access: {8'h00, addr[0] ? per_dout[15:8] : per_dout[7:0]}.
  - Next state: BUS_RD → RESP; RMW_RD → RMW_WR.
- BUS_WR / RMW_WR:
  - per_en=1.
  - per_wen = 11 for word; 10 for byte with addr[0]=1; 01 for byte with addr[0]=0.
  - Byte data is replicated on both lanes: per_din = {b,b}.
  - RMW write value = captured old value | mask (set) or & ~mask (clear), byte-masked for byte ops.
  - Next state: RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable.
  - Exits to IDLE on rsp_ready; a new request can be accepted on the following cycle (no overlap).
- Latency from the accept edge:
  - read/write: bus cycle at +1, rsp_valid at +2.
  - RMW: bus cycles at +1 and +2, rsp_valid at +3.
  - error: rsp_valid at +1.
- Bus signal rules:
  - per_en is high for exactly one cycle per bus access.
  - Between the RMW_RD and RMW_WR cycles per_en stays high, and per_addr is unchanged across them.
  - Outside bus states: per_en=0, per_wen=00, per_din=0 (the OR-bus requires idle zeros).
- rsp_ready may be held high permanently; this gives back-to-back throughput of one op per 3 cycles (read/write).

Test Plan:
- Word read at addr 0x056, peripheral returns 0x3000 → one per_en cycle with per_addr=0x2B, per_wen=00; rsp_rdata=0x3000 at +2; rsp_err=0.
- Byte write 0x0E to addr 0x058, then byte read of addr 0x057 with per_dout=0x3000 →
  - write: per_wen=01, per_din=0x0E0E, per_addr=0x2C.
  - read: rsp_rdata=0x0030.
- Bit-set mask 0x0004 on word 0x0120 holding 0x0081 → read cycle at +1; write cycle at +2 with per_wen=11, per_din=0x0085; rsp_rdata=0x0081 at +3.
- Word read at odd addr 0x057 → no per_en ever asserted; rsp_err=1, rsp_rdata=0 at +1. With RMW_EN=0, a bit-clear request gives the same result.
- rsp_ready held low for 5 cycles → rsp_valid and rsp_rdata stable and req_ready=0 throughout; one cycle after the handshake, req_ready=1.
- puc asserted in the cycle after an RMW accept (during RMW_RD) → next cycle per_en=0, rsp_valid=0, req_ready=1; no write issued.
